// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared defaults and saturating-increment helper for the match logger
//   TS_W_DEF / DEPTH_DEF / CNT_W_DEF : default timestamp width, FIFO depth, counter width
//   sat_inc(v, w)                    : v + 1, held at 2^w - 1 once reached
package seq_det_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    // Works on a 32-bit carrier so one function serves any counter width up to 32.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/seq_match_logger_if.sv
// rtl/seq_match_logger_if.sv - valid/ready event stream carrying match timestamps
//   valid : head entry present (driven by master)
//   ready : consumer accepts the head entry (driven by slave)
//   ts    : timestamp of the head entry (driven by master)
interface seq_match_logger_if
    import seq_det_pkg::*;
#(
    parameter int TS_W = TS_W_DEF
);

    logic            valid;
    logic            ready;
    logic [TS_W-1:0] ts;

    modport master (output valid, output ts, input ready);
    modport slave  (input valid, input ts, output ready);

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO, accepts push and pop together when full
//   clk, rst    : clock, synchronous active-high reset
//   push, din   : write request and data (dropped when full unless popping)
//   pop         : remove head entry (ignored when empty)
//   dout        : head entry, 0 when empty
//   full, empty : registered occupancy flags
module sync_fifo
    import seq_det_pkg::*;
#(
    parameter int W     = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          pop_ok;
    logic          push_ok;

    // Pop is resolved first, so a full FIFO that is also popping can take the write.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/seq_match_logger.sv
// rtl/seq_match_logger.sv - timestamps rising edges of det and queues them for a consumer
//   clk, rst             : clock, synchronous active-high reset
//   det                  : detector match level
//   ev                   : master side of the timestamp stream (valid/ready/ts)
//   fifo_full/fifo_empty : FIFO occupancy flags
//   match_cnt            : saturating count of all events
//   drop_cnt             : saturating count of events lost to overflow
module seq_match_logger
    import seq_det_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 det,
    seq_match_logger_if.master   ev,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic [CNT_W-1:0]     match_cnt,
    output logic [CNT_W-1:0]     drop_cnt
);

    logic [TS_W-1:0] ts;
    logic            det_q;
    logic            hit;
    logic            pop;
    logic            drop;

    assign hit  = det & ~det_q;
    assign pop  = ev.valid & ev.ready;
    assign drop = hit & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts        <= '0;
            det_q     <= 1'b0;
            match_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            ts    <= ts + TS_W'(1);
            det_q <= det;
            if (hit)  match_cnt <= CNT_W'(sat_inc(32'(match_cnt), CNT_W));
            if (drop) drop_cnt  <= CNT_W'(sat_inc(32'(drop_cnt), CNT_W));
        end
    end

    sync_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (hit),
        .din   (ts),
        .pop   (pop),
        .dout  (ev.ts),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ev.valid = ~fifo_empty;

endmodule
